// File: rtl/reg_watch_monitor.sv
// Run monitor: snoops regfile writes and committed PC, ends a run on watch match, halt PC or cycle budget.
// Latency: one cycle from sampled hit/halt/budget inputs to registered done/pass/halted/timed_out.
// Backpressure: none; pure observer, every input is sampled on every clock.
module reg_watch_monitor #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4,
    parameter int CYC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_mode_all,
    input  logic [NUM_CH-1:0]      cfg_ch_en,
    input  logic [5*NUM_CH-1:0]    cfg_ch_addr,
    input  logic [XLEN*NUM_CH-1:0] cfg_ch_value,
    input  logic                   cfg_halt_en,
    input  logic [XLEN-1:0]        cfg_halt_pc,
    input  logic [CYC_W-1:0]       cfg_timeout,
    input  logic                   rf_we,
    input  logic [4:0]             rf_waddr,
    input  logic [XLEN-1:0]        rf_wdata,
    input  logic                   pc_valid,
    input  logic [XLEN-1:0]        pc,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   halted,
    output logic                   timed_out,
    output logic [NUM_CH-1:0]      match_mask,
    output logic [CYC_W-1:0]       cycle_count,
    output logic [XLEN-1:0]        final_pc
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic                    mode_all_q;
    logic [NUM_CH-1:0]       en_q;
    logic [5*NUM_CH-1:0]     addr_q;
    logic [XLEN*NUM_CH-1:0]  value_q;
    logic                    halt_en_q;
    logic [XLEN-1:0]         halt_pc_q;
    logic [CYC_W-1:0]        timeout_q;

    logic [NUM_CH-1:0]       hits;
    logic [NUM_CH-1:0]       seen;
    logic                    match_hit;
    logic                    halt_hit;
    logic                    timeout_hit;
    logic [CYC_W-1:0]        cnt_next;

    // A write to x0 can never be a meaningful result, so addr 0 channels stay silent.
    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hits[i] = (state == RUN) && en_q[i] && rf_we
                      && (rf_waddr == addr_q[5*i +: 5]) && (rf_waddr != 5'd0)
                      && (rf_wdata == value_q[XLEN*i +: XLEN]);
        end
    end

    assign seen        = match_mask | hits;
    assign match_hit   = mode_all_q ? ((en_q != '0) && ((seen & en_q) == en_q))
                                    : ((seen & en_q) != '0);
    assign halt_hit    = halt_en_q && pc_valid && (pc == halt_pc_q);
    assign timeout_hit = (timeout_q != '0) && ((cycle_count + CYC_W'(1)) == timeout_q);
    assign cnt_next    = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode_all_q  <= 1'b0;
            en_q        <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            halt_en_q   <= 1'b0;
            halt_pc_q   <= '0;
            timeout_q   <= '0;
            pass        <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            match_mask  <= '0;
            cycle_count <= '0;
            final_pc    <= '0;
        end else if (start) begin
            state       <= RUN;
            mode_all_q  <= cfg_mode_all;
            en_q        <= cfg_ch_en;
            addr_q      <= cfg_ch_addr;
            value_q     <= cfg_ch_value;
            halt_en_q   <= cfg_halt_en;
            halt_pc_q   <= cfg_halt_pc;
            timeout_q   <= cfg_timeout;
            pass        <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            match_mask  <= '0;
            cycle_count <= '0;
        end else if (state == RUN) begin
            match_mask  <= seen;
            cycle_count <= cnt_next;
            if (pc_valid) begin
                final_pc <= pc;
            end
            // Exactly one cause is reported; a watch match outranks halt, halt outranks budget.
            if (match_hit) begin
                pass  <= 1'b1;
                state <= DONE;
            end else if (halt_hit) begin
                halted <= 1'b1;
                state  <= DONE;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
                state     <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_reg_watch_monitor.sv
// Bench for reg_watch_monitor: scenario table, directed corner sequences and random runs vs a behavioural model.
module tb_reg_watch_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cfg_mode_all;
    logic [3:0]   cfg_ch_en;
    logic [19:0]  cfg_ch_addr;
    logic [127:0] cfg_ch_value;
    logic         cfg_halt_en;
    logic [31:0]  cfg_halt_pc;
    logic [15:0]  cfg_timeout;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         pc_valid;
    logic [31:0]  pc;
    logic         busy, done, pass, halted, timed_out;
    logic [3:0]   match_mask;
    logic [15:0]  cycle_count;
    logic [31:0]  final_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_watch_monitor #(.XLEN(32), .NUM_CH(4), .CYC_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_mode_all(cfg_mode_all), .cfg_ch_en(cfg_ch_en), .cfg_ch_addr(cfg_ch_addr),
        .cfg_ch_value(cfg_ch_value), .cfg_halt_en(cfg_halt_en), .cfg_halt_pc(cfg_halt_pc),
        .cfg_timeout(cfg_timeout), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_valid(pc_valid), .pc(pc), .busy(busy), .done(done), .pass(pass), .halted(halted),
        .timed_out(timed_out), .match_mask(match_mask), .cycle_count(cycle_count),
        .final_pc(final_pc)
    );

    // Behavioural model: run status, sticky flags and counters as plain variables.
    bit          m_run, m_done, m_pass, m_halt, m_to;
    bit [3:0]    m_mask;
    bit [15:0]   m_cnt;
    bit [31:0]   m_fpc;
    bit          l_all, l_hen;
    bit [3:0]    l_en;
    bit [4:0]    l_addr [4];
    bit [31:0]   l_val  [4];
    bit [31:0]   l_hpc;
    int          l_tmo;

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_halt = 0; m_to = 0;
        m_mask = 0; m_cnt = 0; m_fpc = 0;
    endfunction

    function automatic void model_step();
        int n_en, n_seen;
        bit matched, halt_now, budget_out;
        if (!rst) begin
            model_reset();
            return;
        end
        if (start) begin
            l_all = cfg_mode_all; l_en = cfg_ch_en; l_hen = cfg_halt_en;
            l_hpc = cfg_halt_pc; l_tmo = int'(cfg_timeout);
            for (int i = 0; i < 4; i++) begin
                l_addr[i] = cfg_ch_addr[5*i +: 5];
                l_val[i]  = cfg_ch_value[32*i +: 32];
            end
            m_run = 1; m_done = 0; m_pass = 0; m_halt = 0; m_to = 0;
            m_mask = 0; m_cnt = 0;
            return;
        end
        if (!m_run) return;
        n_en = 0; n_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (l_en[i] && rf_we && rf_waddr != 0 && rf_waddr == l_addr[i] && rf_wdata == l_val[i])
                m_mask[i] = 1;
            if (l_en[i]) begin
                n_en++;
                if (m_mask[i]) n_seen++;
            end
        end
        matched    = l_all ? (n_en > 0 && n_seen == n_en) : (n_seen > 0);
        halt_now   = l_hen && pc_valid && pc == l_hpc;
        budget_out = (l_tmo != 0) && (int'(m_cnt) + 1 == l_tmo);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (pc_valid) m_fpc = pc;
        if (matched)         m_pass = 1;
        else if (halt_now)   m_halt = 1;
        else if (budget_out) m_to = 1;
        if (matched || halt_now || budget_out) begin
            m_run = 0; m_done = 1;
        end
    endfunction

    function automatic logic [63:0] dut_vec();
        return {7'd0, busy, done, pass, halted, timed_out, match_mask, cycle_count, final_pc};
    endfunction

    function automatic logic [63:0] model_vec();
        return {7'd0, m_run, m_done, m_pass, m_halt, m_to, m_mask, m_cnt, m_fpc};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk($sformatf("cycle@%0t", $time), dut_vec(), model_vec());
    endtask

    task automatic quiet();
        start = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0; pc_valid = 0; pc = 0;
    endtask

    task automatic set_cfg(input logic all, input logic [3:0] en, input logic [19:0] addr,
                           input logic [127:0] val, input logic hen, input logic [31:0] hpc,
                           input logic [15:0] tmo);
        cfg_mode_all = all; cfg_ch_en = en; cfg_ch_addr = addr; cfg_ch_value = val;
        cfg_halt_en = hen; cfg_halt_pc = hpc; cfg_timeout = tmo;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1; rf_waddr = a; rf_wdata = d;
    endtask

    typedef struct {
        logic         mode_all;
        logic [3:0]   en;
        logic [19:0]  addr;
        logic [127:0] val;
        logic         halt_en;
        logic [31:0]  halt_pc;
        logic [15:0]  tmo;
        int           wa_cyc;
        logic [4:0]   wa_addr;
        logic [31:0]  wa_dat;
        int           wb_cyc;
        logic [4:0]   wb_addr;
        logic [31:0]  wb_dat;
        int           pc_cyc;
        logic [31:0]  pcv;
        logic         e_pass, e_halt, e_to;
        logic [3:0]   e_mask;
        logic [15:0]  e_cnt;
        logic [31:0]  e_fpc;
    } scen_t;

    scen_t tbl [8];

    initial begin
        bit fin;
        tbl[0] = '{1'b0, 4'b0001, {5'd0,5'd0,5'd0,5'd10}, {32'd0,32'd0,32'd0,32'd49}, 1'b0, 32'h0, 16'd100,
                   2, 5'd10, 32'd7, 5, 5'd10, 32'd49, 3, 32'h200, 1'b1, 1'b0, 1'b0, 4'b0001, 16'd5, 32'h200};
        tbl[1] = '{1'b0, 4'b0001, {5'd0,5'd0,5'd0,5'd10}, {32'd0,32'd0,32'd0,32'd49}, 1'b0, 32'h0, 16'd20,
                   4, 5'd10, 32'd1, 6, 5'd11, 32'd49, 10, 32'h300, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd20, 32'h300};
        tbl[2] = '{1'b0, 4'b0010, {5'd0,5'd0,5'd5,5'd0}, {32'd0,32'd0,32'd9,32'd0}, 1'b1, 32'h400, 16'd0,
                   3, 5'd5, 32'd8, 0, 5'd0, 32'd0, 7, 32'h400, 1'b0, 1'b1, 1'b0, 4'b0000, 16'd7, 32'h400};
        tbl[3] = '{1'b0, 4'b0110, {5'd0,5'd4,5'd3,5'd0}, {32'd0,32'd22,32'd11,32'd0}, 1'b0, 32'h0, 16'd0,
                   3, 5'd4, 32'd22, 0, 5'd0, 32'd0, 1, 32'h500, 1'b1, 1'b0, 1'b0, 4'b0100, 16'd3, 32'h500};
        tbl[4] = '{1'b0, 4'b0001, 20'd0, 128'd0, 1'b0, 32'h0, 16'd6,
                   2, 5'd0, 32'd0, 0, 5'd0, 32'd0, 2, 32'h600, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd6, 32'h600};
        tbl[5] = '{1'b0, 4'b0000, {5'd0,5'd0,5'd0,5'd7}, {32'd0,32'd0,32'd0,32'd1}, 1'b0, 32'h0, 16'd4,
                   2, 5'd7, 32'd1, 0, 5'd0, 32'd0, 1, 32'h700, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd4, 32'h700};
        tbl[6] = '{1'b1, 4'b0001, {5'd0,5'd0,5'd2,5'd1}, {32'd0,32'd0,32'd2,32'd1}, 1'b0, 32'h0, 16'd0,
                   1, 5'd2, 32'd2, 3, 5'd1, 32'd1, 3, 32'h800, 1'b1, 1'b0, 1'b0, 4'b0001, 16'd3, 32'h800};
        tbl[7] = '{1'b0, 4'b0000, 20'd0, 128'd0, 1'b0, 32'h0, 16'd1,
                   0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 32'h900, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd1, 32'h900};

        rst = 0;
        quiet();
        set_cfg(1'b0, 4'b0, 20'd0, 128'd0, 1'b0, 32'h0, 16'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 64'd0);
        rst = 1;

        for (int s = 0; s < 8; s++) begin
            set_cfg(tbl[s].mode_all, tbl[s].en, tbl[s].addr, tbl[s].val,
                    tbl[s].halt_en, tbl[s].halt_pc, tbl[s].tmo);
            pulse_start();
            fin = 0;
            for (int c = 1; c <= 60 && !fin; c++) begin
                quiet();
                if (c == tbl[s].wa_cyc) wr(tbl[s].wa_addr, tbl[s].wa_dat);
                if (c == tbl[s].wb_cyc) wr(tbl[s].wb_addr, tbl[s].wb_dat);
                if (c == tbl[s].pc_cyc) begin pc_valid = 1; pc = tbl[s].pcv; end
                tick();
                fin = done;
            end
            quiet();
            chk($sformatf("scen%0d_done", s), {63'd0, done}, 64'd1);
            chk($sformatf("scen%0d_result", s),
                {7'd0, pass, halted, timed_out, match_mask, cycle_count, final_pc},
                {7'd0, tbl[s].e_pass, tbl[s].e_halt, tbl[s].e_to, tbl[s].e_mask, tbl[s].e_cnt, tbl[s].e_fpc});
        end

        // ALL mode: partial match must stay sticky until the second channel arrives.
        set_cfg(1'b1, 4'b0011, {5'd0,5'd0,5'd9,5'd8}, {32'd0,32'd0,32'd5,32'd3}, 1'b0, 32'h0, 16'd0);
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            quiet();
            if (c == 2) wr(5'd8, 32'd3);
            if (c == 3) wr(5'd9, 32'd4);
            if (c == 6) wr(5'd9, 32'd5);
            tick();
            if (c == 2) chk("all_partial", {59'd0, busy, done, match_mask}, {59'd0, 1'b1, 1'b0, 4'b0001});
        end
        quiet();
        chk("all_final", {43'd0, done, pass, match_mask, cycle_count}, {43'd0, 1'b1, 1'b1, 4'b0011, 16'd6});

        // Priority: match, halt and budget expiry on the same edge; cfg scrambled mid-run.
        set_cfg(1'b0, 4'b0001, {5'd0,5'd0,5'd0,5'd10}, {32'd0,32'd0,32'd0,32'd1}, 1'b1, 32'h108, 16'd4);
        pulse_start();
        set_cfg(1'b1, 4'b0000, 20'd0, 128'd0, 1'b0, 32'h0, 16'd0);
        for (int c = 1; c <= 4; c++) begin
            quiet();
            if (c == 4) begin wr(5'd10, 32'd1); pc_valid = 1; pc = 32'h108; end
            tick();
        end
        quiet();
        chk("priority", {27'd0, done, pass, halted, timed_out, cycle_count, final_pc},
            {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 32'h108});

        // x0 watch never fires; then restart from DONE and from RUN.
        set_cfg(1'b0, 4'b0001, 20'd0, 128'd0, 1'b0, 32'h0, 16'd3);
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            quiet();
            wr(5'd0, 32'd0);
            tick();
        end
        quiet();
        chk("x0_result", {56'd0, done, pass, halted, timed_out, match_mask},
            {56'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000});
        set_cfg(1'b1, 4'b0011, {5'd0,5'd0,5'd2,5'd1}, {32'd0,32'd0,32'd2,32'd1}, 1'b0, 32'h0, 16'd0);
        pulse_start();
        chk("restart_done", {41'd0, busy, done, timed_out, match_mask, cycle_count},
            {41'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0});
        wr(5'd1, 32'd1);
        tick();
        quiet();
        chk("run_partial", {44'd0, match_mask, cycle_count}, {44'd0, 4'b0001, 16'd1});
        pulse_start();
        chk("restart_run", {43'd0, busy, done, match_mask, cycle_count}, {43'd0, 1'b1, 1'b0, 4'b0000, 16'd0});

        // Asynchronous reset between edges, then no activity until a new start.
        pc_valid = 1; pc = 32'h44;
        tick();
        tick();
        quiet();
        #3;
        rst = 0;
        #1;
        model_reset();
        chk("async_reset", dut_vec(), 64'd0);
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            wr(5'd1, 32'd1); pc_valid = 1; pc = 32'h108;
            tick();
        end
        quiet();
        chk("post_reset_idle", dut_vec(), 64'd0);

        // Random runs, occasionally restarted mid-run.
        for (int r = 0; r < 40; r++) begin
            logic [19:0] ad;
            logic [127:0] va;
            for (int i = 0; i < 4; i++) begin
                ad[5*i +: 5]  = 5'($urandom_range(0, 3));
                va[32*i +: 32] = 32'($urandom_range(0, 3));
            end
            set_cfg(1'($urandom), 4'($urandom), ad, va, 1'($urandom),
                    32'h100 + 32'($urandom_range(0, 3) * 4), 16'($urandom_range(0, 25)));
            pulse_start();
            fin = 0;
            for (int c = 0; c < 40 && !fin; c++) begin
                quiet();
                start    = ($urandom_range(0, 49) == 0);
                rf_we    = 1'($urandom);
                rf_waddr = 5'($urandom_range(0, 3));
                rf_wdata = 32'($urandom_range(0, 3));
                pc_valid = 1'($urandom);
                pc       = 32'h100 + 32'($urandom_range(0, 3) * 4);
                tick();
                fin = done;
            end
            quiet();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_watch_monitor.md
# reg_watch_monitor

Synthesizable, parametrised run monitor for the RV32I core. It snoops the register-file write port and the committed PC and detects end-of-program conditions in hardware, replacing per-test polling of regfile contents. A run ends when any or all of NUM_CH programmable register/value watches match, when a halt PC is reached, or when a cycle budget expires. Pass/fail, cycle count and the final PC are reported. It sits beside `cpu`, driven by the same clock and reset.

## Interface
Parameters:
- XLEN, 32, data/PC width
- NUM_CH, 4, number of watch channels (1..8)
- CYC_W, 16, cycle counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse: latch config, clear results, enter RUN
- cfg_mode_all  in  1  1: pass when all enabled channels have matched; 0: pass on any enabled channel
- cfg_ch_en  in  NUM_CH  channel enables
- cfg_ch_addr  in  5*NUM_CH  channel i register index at bits [5i+4:5i]
- cfg_ch_value  in  XLEN*NUM_CH  channel i expected value
- cfg_halt_en  in  1  enable halt-PC detection
- cfg_halt_pc  in  XLEN  halt PC
- cfg_timeout  in  CYC_W  cycle budget; 0 disables timeout
- rf_we, rf_waddr[4:0], rf_wdata[XLEN-1:0]  in  snooped regfile write port
- pc_valid  in  1  pc is a committed fetch address this cycle
- pc  in  XLEN  current PC
- busy  out  1  state is RUN
- done  out  1  run terminated; held until the next start
- pass  out  1  terminated by a watch match
- halted  out  1  terminated by halt PC
- timed_out  out  1  terminated by budget
- match_mask  out  NUM_CH  sticky per-channel match flags
- cycle_count  out  CYC_W  RUN cycles elapsed
- final_pc  out  XLEN  last valid PC seen at termination

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE, with every output at 0.
- IDLE/DONE + start → RUN.
  - On entry, the cfg_* inputs are latched into internal registers. Config changes during RUN are ignored.
  - Clears match_mask, cycle_count, pass, halted, timed_out and done.
  - final_pc holds its value.
- start in RUN restarts the run with the same clearing and latching.
- Channel i hits in a cycle when all of these hold:
  - state is RUN
  - latched en[i] is set
  - rf_we is set
  - rf_waddr == addr[i]
  - rf_waddr != 0
  - rf_wdata == value[i]
- A write that does not match does not clear an earlier hit. match_mask bits are sticky.
- A channel with addr 0 never hits.
- Match condition uses match_mask | hits (the current cycle's hits count):
  - ALL mode: every enabled bit is set, and at least one channel is enabled.
  - ANY mode: any enabled bit is set.
  - No channels enabled → match never fires.
- Halt condition: latched halt_en && pc_valid && pc == halt_pc.
- Timeout condition: latched timeout != 0 && cycle_count + 1 == timeout.
- Termination priority in the same cycle: match > halt > timeout. Exactly one of pass/halted/timed_out is set. The state goes to DONE and done is set.
- cycle_count increments on every RUN edge, including the terminating edge. With timeout disabled it saturates at all-ones.
- final_pc is updated with pc on every RUN edge where pc_valid is set. It is frozen in DONE and IDLE.
- Reset asserted mid-run forces IDLE and zeroes all outputs immediately (asynchronously).

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- start at edge N → busy=1 after edge N. Snooping starts with inputs sampled at edge N+1.
- Hit inputs sampled at edge M → done/pass, match_mask and cycle_count visible after edge M (1-cycle latency).
- The first RUN sample terminating gives cycle_count=1.
- Timeout T: done/timed_out set after the T-th RUN edge, with cycle_count=T.
- match_mask updates in the same edge as the hit, including on the terminating edge.

## Test plan
- Exponentiation-style run:
  - Setup: ch0 addr=10 value=49, ANY, timeout=100.
  - Stimulus: writes x10=7, then x10=49 on the 5th RUN cycle.
  - Required response: pass=1, match_mask=0001, cycle_count=5, timed_out=0.
- ALL mode:
  - Setup: ch0 x8=3, ch1 x9=5.
  - Stimulus: x8=3 on cycle 2, x9=4 on cycle 3, x9=5 on cycle 6.
  - Required response: mask=0001 after cycle 2, pass on cycle 6, mask=0011, cycle_count=6.
- Timeout:
  - Setup: timeout=20, no matching writes.
  - Required response: timed_out=1, done=1, pass=0, cycle_count=20.
- Priority:
  - Stimulus: the match write, a halt-PC hit (pc=0x108) and the timeout edge all occur in the same cycle.
  - Required response: pass=1, halted=0, timed_out=0, final_pc=0x108.
- x0/restart:
  - Stimulus: ch0 addr=0 with a write x0=0, followed by timeout; then start again with a fresh config.
  - Required response: after the first run, only timed_out is set; after the restart, mask=0, cycle_count=0, busy=1.
- Reset mid-run:
  - Stimulus: assert rst low between clock edges during RUN.
  - Required response: all outputs 0 immediately; no state change on the following edges until start.
